// File: rtl/lcd_pkg.sv
// Definitions shared by the display write side and the scan-out side:
// DCS command codes, bus controller states and default panel geometry.
package lcd_pkg;

    localparam int unsigned HActDefault = 800;
    localparam int unsigned VActDefault = 480;

    localparam logic [7:0] CmdSoftReset    = 8'h01;
    localparam logic [7:0] CmdDispOff      = 8'h28;
    localparam logic [7:0] CmdDispOn       = 8'h29;
    localparam logic [7:0] CmdMemWrite     = 8'h2C;
    localparam logic [7:0] CmdMemWriteCont = 8'h3C;
    localparam logic [7:0] CmdSetBright    = 8'h51;

    localparam logic [7:0] BlLevelReset = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StParam,
        StMemWr
    } bus_state_e;

endpackage

// File: rtl/bus_sync.sv
// Synchronises the asynchronous i8080 bus pins into the system clock domain and
// flags a write event on a synchronised nWR rising edge while nCS is low.
module bus_sync #(
    parameter int unsigned Stages = 2,
    parameter int unsigned Width  = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ncs_i,
    input  logic             nwr_i,
    input  logic             dc_i,
    input  logic [Width-1:0] d_i,
    output logic             wr_evt_o,
    output logic             dc_o,
    output logic [Width-1:0] d_o
);

    localparam int unsigned BusW = Width + 3;
    // Bus word layout {ncs, nwr, dc, d}; reset to an idle bus so no event fires.
    localparam logic [BusW-1:0] IdleBus = {2'b11, {(Width + 1){1'b0}}};

    logic [BusW-1:0] sync_q [Stages];
    logic            nwr_prev_q;
    logic            ncs_s;
    logic            nwr_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Stages; i++) begin
                sync_q[i] <= IdleBus;
            end
            nwr_prev_q <= 1'b1;
        end else begin
            sync_q[0] <= {ncs_i, nwr_i, dc_i, d_i};
            for (int i = 1; i < Stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            nwr_prev_q <= nwr_s;
        end
    end

    always_comb begin
        ncs_s    = sync_q[Stages-1][BusW-1];
        nwr_s    = sync_q[Stages-1][BusW-2];
        dc_o     = sync_q[Stages-1][Width];
        d_o      = sync_q[Stages-1][Width-1:0];
        wr_evt_o = nwr_s & ~nwr_prev_q & ~ncs_s;
    end

endmodule

// File: rtl/i8080_bus_ctrl.sv
// i8080 (DBI type B, 8-bit) write-side controller: decodes DCS commands,
// streams memory-write bytes into the display FIFO and owns backlight state.
module i8080_bus_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned H_ACT       = HActDefault,
    parameter int unsigned V_ACT       = VActDefault,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       I_nCS,
    input  logic       I_nWR,
    input  logic       I_DC,
    input  logic [7:0] I_D,
    input  logic       FIFO_Full,
    output logic       FIFO_WE,
    output logic [7:0] FIFO_DI,
    output logic       LCD_BL,
    output logic [7:0] BL_Level,
    output logic       FrameStart,
    output logic       Overflow,
    output logic       Busy
);

    localparam int unsigned FrameBytes = 2 * H_ACT * V_ACT;
    localparam int unsigned CntW       = $clog2(FrameBytes + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FrameBytes);

    logic       wr_evt;
    logic       wr_dc;
    logic [7:0] wr_data;

    bus_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      bl_level_q, bl_level_d;
    logic            disp_on_q, disp_on_d;
    logic            lcd_bl_q, lcd_bl_d;
    logic            fifo_we_q, fifo_we_d;
    logic [7:0]      fifo_di_q, fifo_di_d;
    logic            frame_start_q, frame_start_d;

    bus_sync #(
        .Stages(SYNC_STAGES),
        .Width (8)
    ) u_bus_sync (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .ncs_i   (I_nCS),
        .nwr_i   (I_nWR),
        .dc_i    (I_DC),
        .d_i     (I_D),
        .wr_evt_o(wr_evt),
        .dc_o    (wr_dc),
        .d_o     (wr_data)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            bl_level_q    <= BlLevelReset;
            disp_on_q     <= 1'b0;
            lcd_bl_q      <= 1'b0;
            fifo_we_q     <= 1'b0;
            fifo_di_q     <= 8'h00;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            bl_level_q    <= bl_level_d;
            disp_on_q     <= disp_on_d;
            lcd_bl_q      <= lcd_bl_d;
            fifo_we_q     <= fifo_we_d;
            fifo_di_q     <= fifo_di_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        bl_level_d    = bl_level_q;
        disp_on_d     = disp_on_q;
        fifo_we_d     = 1'b0;
        fifo_di_d     = fifo_di_q;
        frame_start_d = 1'b0;

        if (wr_evt && !wr_dc) begin
            // Every command aborts whatever was in progress.
            case (wr_data)
                CmdMemWrite: begin
                    state_d       = StMemWr;
                    cnt_d         = '0;
                    ovf_d         = 1'b0;
                    frame_start_d = 1'b1;
                end
                CmdMemWriteCont: state_d = (cnt_q == CntMax) ? StIdle : StMemWr;
                CmdSetBright:    state_d = StParam;
                CmdDispOff: begin
                    disp_on_d = 1'b0;
                    state_d   = StIdle;
                end
                CmdDispOn: begin
                    disp_on_d = 1'b1;
                    state_d   = StIdle;
                end
                CmdSoftReset: begin
                    state_d    = StIdle;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    bl_level_d = BlLevelReset;
                    disp_on_d  = 1'b0;
                    fifo_di_d  = 8'h00;
                end
                default: state_d = StIdle;
            endcase
        end else if (wr_evt) begin
            case (state_q)
                StParam: begin
                    bl_level_d = wr_data;
                    state_d    = StIdle;
                end
                StMemWr: begin
                    if (!FIFO_Full) begin
                        fifo_we_d = 1'b1;
                        fifo_di_d = wr_data;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_d == CntMax) begin
                        state_d = StIdle;
                    end
                end
                default: ;
            endcase
        end

        lcd_bl_d = disp_on_d & (bl_level_d != 8'h00);
    end

    always_comb begin
        FIFO_WE    = fifo_we_q;
        FIFO_DI    = fifo_di_q;
        LCD_BL     = lcd_bl_q;
        BL_Level   = bl_level_q;
        FrameStart = frame_start_q;
        Overflow   = ovf_q;
        Busy       = (state_q == StMemWr);
    end

endmodule

// File: tb/tb_i8080_bus_ctrl.sv
// Bench for i8080_bus_ctrl: directed bus sequences followed by random traffic,
// all checked against a transaction-level model of the command/data rules.
module tb_i8080_bus_ctrl;

    localparam int unsigned HAct  = 4;
    localparam int unsigned VAct  = 2;
    localparam int          Total = 2 * HAct * VAct;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       I_nCS;
    logic       I_nWR;
    logic       I_DC;
    logic [7:0] I_D;
    logic       FIFO_Full;
    logic       FIFO_WE;
    logic [7:0] FIFO_DI;
    logic       LCD_BL;
    logic [7:0] BL_Level;
    logic       FrameStart;
    logic       Overflow;
    logic       Busy;

    always #5 CLK = ~CLK;

    i8080_bus_ctrl #(
        .H_ACT      (HAct),
        .V_ACT      (VAct),
        .SYNC_STAGES(2)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .I_nCS     (I_nCS),
        .I_nWR     (I_nWR),
        .I_DC      (I_DC),
        .I_D       (I_D),
        .FIFO_Full (FIFO_Full),
        .FIFO_WE   (FIFO_WE),
        .FIFO_DI   (FIFO_DI),
        .LCD_BL    (LCD_BL),
        .BL_Level  (BL_Level),
        .FrameStart(FrameStart),
        .Overflow  (Overflow),
        .Busy      (Busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int we_seen  = 0;
    int fs_seen  = 0;

    // Reference model: pixel-stream and brightness-parameter bookkeeping.
    bit         m_in_frame;
    bit         m_want_param;
    bit         m_disp;
    bit         m_ovf;
    logic [7:0] m_bl;
    int         m_bytes;
    int         m_we_total = 0;
    int         m_fs_total = 0;

    always @(negedge CLK) begin
        if (nRST === 1'b1 && FIFO_WE === 1'b1) we_seen++;
        if (nRST === 1'b1 && FrameStart === 1'b1) fs_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame   = 1'b0;
        m_want_param = 1'b0;
        m_disp       = 1'b0;
        m_ovf        = 1'b0;
        m_bl         = 8'hFF;
        m_bytes      = 0;
    endtask

    task automatic model_cmd(input logic [7:0] c);
        m_in_frame   = 1'b0;
        m_want_param = 1'b0;
        if (c == 8'h2C) begin
            m_in_frame = 1'b1;
            m_bytes    = 0;
            m_ovf      = 1'b0;
        end else if (c == 8'h3C) begin
            m_in_frame = (m_bytes < Total);
        end else if (c == 8'h51) begin
            m_want_param = 1'b1;
        end else if (c == 8'h28) begin
            m_disp = 1'b0;
        end else if (c == 8'h29) begin
            m_disp = 1'b1;
        end else if (c == 8'h01) begin
            model_reset();
        end
    endtask

    task automatic model_data(input logic [7:0] d, input bit full, output bit we);
        we = 1'b0;
        if (m_want_param) begin
            m_bl         = d;
            m_want_param = 1'b0;
        end else if (m_in_frame) begin
            if (full) m_ovf = 1'b1;
            else      we = 1'b1;
            m_bytes++;
            if (m_bytes == Total) m_in_frame = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, FIFO_WE, 0);
        check({tag, "_di"}, FIFO_DI, 8'h00);
        check({tag, "_lcd_bl"}, LCD_BL, 0);
        check({tag, "_bl_level"}, BL_Level, 8'hFF);
        check({tag, "_fs"}, FrameStart, 0);
        check({tag, "_ovf"}, Overflow, 0);
        check({tag, "_busy"}, Busy, 0);
    endtask

    // One bus write: nWR low 3 cycles, high 4; outputs due 3 cycles after the rise.
    task automatic bus_xfer(input bit dc, input logic [7:0] d, input bit full);
        bit exp_we;
        bit exp_fs;
        @(negedge CLK);
        I_nCS = 1'b0;
        I_DC  = dc;
        I_D   = d;
        I_nWR = 1'b0;
        repeat (3) @(negedge CLK);
        I_nWR     = 1'b1;
        FIFO_Full = full;
        if (!dc) begin
            model_cmd(d);
            exp_we = 1'b0;
            exp_fs = (d == 8'h2C);
        end else begin
            model_data(d, full, exp_we);
            exp_fs = 1'b0;
        end
        if (exp_we) m_we_total++;
        if (exp_fs) m_fs_total++;
        @(negedge CLK);
        check("we_early1", FIFO_WE, 0);
        @(negedge CLK);
        check("we_early2", FIFO_WE, 0);
        @(negedge CLK);
        check("we", FIFO_WE, exp_we);
        if (exp_we) check("di", FIFO_DI, d);
        check("frame_start", FrameStart, exp_fs);
        check("busy", Busy, m_in_frame);
        check("overflow", Overflow, m_ovf);
        check("bl_level", BL_Level, m_bl);
        check("lcd_bl", LCD_BL, m_disp && (m_bl != 8'h00));
        @(negedge CLK);
        check("we_single", FIFO_WE, 0);
        check("fs_single", FrameStart, 0);
    endtask

    // Chip-select gap with a stray nWR pulse that must not count as a write.
    task automatic cs_gap();
        int base;
        base = we_seen;
        @(negedge CLK);
        I_nCS = 1'b1;
        repeat (4) @(negedge CLK);
        I_nWR = 1'b0;
        repeat (3) @(negedge CLK);
        I_nWR = 1'b1;
        repeat (5) @(negedge CLK);
        I_nCS = 1'b0;
        check("cs_gap_no_we", we_seen - base, 0);
    endtask

    initial begin
        int base_we;
        int base_fs;
        logic [7:0] cmds [8];
        cmds[0] = 8'h2C; cmds[1] = 8'h2C; cmds[2] = 8'h3C; cmds[3] = 8'h51;
        cmds[4] = 8'h28; cmds[5] = 8'h29; cmds[6] = 8'h01; cmds[7] = 8'h00;

        I_nCS     = 1'b1;
        I_nWR     = 1'b1;
        I_DC      = 1'b0;
        I_D       = 8'h00;
        FIFO_Full = 1'b0;
        nRST      = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        check_reset_outputs("rst");
        nRST = 1'b1;
        repeat (2) @(negedge CLK);

        // Backlight enable and brightness.
        bus_xfer(0, 8'h29, 0);
        bus_xfer(0, 8'h51, 0);
        bus_xfer(1, 8'h80, 0);
        check("bl_on", LCD_BL, 1);
        check("bl_level_80", BL_Level, 8'h80);
        bus_xfer(0, 8'h51, 0);
        bus_xfer(1, 8'h00, 0);
        check("bl_off_zero", LCD_BL, 0);

        // Short pixel burst.
        base_we = we_seen;
        base_fs = fs_seen;
        bus_xfer(0, 8'h2C, 0);
        for (int i = 0; i < 4; i++) bus_xfer(1, 8'hA1 + 8'(i), 0);
        check("burst4_we", we_seen - base_we, 4);
        check("burst4_fs", fs_seen - base_fs, 1);

        // Terminal count: 16 bytes per frame, the 17th is ignored.
        base_we = we_seen;
        bus_xfer(0, 8'h2C, 0);
        for (int i = 0; i < 15; i++) bus_xfer(1, 8'(i), 0);
        check("busy_before_tc", Busy, 1);
        bus_xfer(1, 8'h0F, 0);
        check("busy_after_tc", Busy, 0);
        bus_xfer(1, 8'h10, 0);
        check("frame_we", we_seen - base_we, Total);

        // Overflow on a full FIFO, cleared by the next frame start.
        base_we = we_seen;
        bus_xfer(0, 8'h2C, 0);
        bus_xfer(1, 8'h11, 0);
        bus_xfer(1, 8'h22, 1);
        bus_xfer(1, 8'h33, 0);
        check("ovf_we", we_seen - base_we, 2);
        check("ovf_set", Overflow, 1);
        bus_xfer(0, 8'h2C, 0);
        check("ovf_clear", Overflow, 0);

        // Continue after an unrelated command.
        base_we = we_seen;
        base_fs = fs_seen;
        bus_xfer(0, 8'h2C, 0);
        for (int i = 0; i < 3; i++) bus_xfer(1, 8'h40 + 8'(i), 0);
        bus_xfer(0, 8'h00, 0);
        bus_xfer(0, 8'h3C, 0);
        bus_xfer(1, 8'h50, 0);
        bus_xfer(1, 8'h51, 0);
        check("cont_we", we_seen - base_we, 5);
        check("cont_fs", fs_seen - base_fs, 1);

        // Asynchronous reset in the middle of a frame.
        bus_xfer(0, 8'h2C, 0);
        bus_xfer(1, 8'h61, 0);
        bus_xfer(1, 8'h62, 0);
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1 check_reset_outputs("async_rst");
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        model_reset();
        base_we = we_seen;
        bus_xfer(1, 8'h63, 0);
        bus_xfer(1, 8'h64, 0);
        check("post_rst_we", we_seen - base_we, 0);
        check_reset_outputs("post_rst");

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 6) cs_gap();
            if (r < 60) begin
                bus_xfer(1, 8'($urandom), $urandom_range(0, 4) == 0);
            end else begin
                int k;
                k = int'($urandom_range(0, 7));
                if (k == 7) bus_xfer(0, 8'($urandom), 0);
                else        bus_xfer(0, cmds[k], 0);
            end
        end

        repeat (4) @(negedge CLK);
        check("we_total", we_seen, m_we_total);
        check("fs_total", fs_seen, m_fs_total);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i8080_bus_ctrl.md
# i8080_bus_ctrl

Write-side controller for the display FIFO: samples an external MCU i8080 (MIPI-DBI type B, 8-bit) bus in the `CLK` domain and decodes command and data bytes. During memory-write it pushes pixel bytes into the FIFO write port, so the scan-out path reads them as 16-bit words. It also owns backlight state and reports frame starts and FIFO overflow. It sits between the MCU pins and the FIFO write port and runs on the 100 MHz system clock.

## Interface
Parameters:
- `H_ACT`, 800, active pixels per line
- `V_ACT`, 480, active lines per frame
- `SYNC_STAGES`, 2, synchroniser depth on all bus inputs (≥2)

Ports:
- `CLK`  in  1  system clock (FIFO write clock)
- `nRST`  in  1  asynchronous active-low reset
- `I_nCS`  in  1  bus chip select, active low, asynchronous to `CLK`
- `I_nWR`  in  1  bus write strobe, active low; data is captured on its rising edge
- `I_DC`  in  1  0 = command byte, 1 = data/parameter byte
- `I_D`  in  8  bus data
- `FIFO_Full`  in  1  FIFO full flag
- `FIFO_WE`  out  1  FIFO write enable, one-cycle pulse per byte
- `FIFO_DI`  out  8  FIFO write data
- `LCD_BL`  out  1  backlight enable
- `BL_Level`  out  8  backlight brightness
- `FrameStart`  out  1  one-cycle pulse on each 0x2C command
- `Overflow`  out  1  sticky flag: a byte was dropped because the FIFO was full
- `Busy`  out  1  high while the FSM is in MEMWR

## Operation
- All bus inputs pass through `SYNC_STAGES` flops. A write event is a synchronised `nWR` 0→1 transition while synchronised `nCS` = 0. The event samples `DC` and `D` from the same synchronised stage.
- FSM states: IDLE, PARAM, MEMWR.
- Command bytes (DC=0) are accepted in any state and abort the current state:
  - 0x2C: go to MEMWR, clear the byte counter, clear `Overflow`, pulse `FrameStart`.
  - 0x3C: go to MEMWR and keep the counter. If the counter is already at terminal count, go to IDLE.
  - 0x51: go to PARAM.
  - 0x28: `disp_on` = 0, go to IDLE.
  - 0x29: `disp_on` = 1, go to IDLE.
  - 0x01 (soft reset): all registers take their reset values, go to IDLE.
  - Any other command: go to IDLE, no other effect.
- PARAM: the first data byte loads `BL_Level`, then go to IDLE.
- MEMWR handling of each data byte:
  - If `FIFO_Full` = 0 in the write cycle: `FIFO_WE` = 1 for one cycle with `FIFO_DI` = byte.
  - Otherwise the byte is dropped and `Overflow` is set.
  - In both cases the counter increments.
  - At count = 2·`H_ACT`·`V_ACT`, go to IDLE.
- Counter width is $clog2(2·H_ACT·V_ACT+1). It is unsigned and never wraps.
- Data bytes in IDLE are ignored.
- `LCD_BL` = `disp_on` & (`BL_Level` ≠ 0), registered.
- `nCS` deassertion does not change FSM state. A transfer may be split across several chip-select periods.
- Reset values: `FIFO_WE` = 0, `FIFO_DI` = 0, `LCD_BL` = 0, `BL_Level` = 0xFF, `FrameStart` = 0, `Overflow` = 0, `Busy` = 0, `disp_on` = 0, FSM = IDLE, counter = 0.
- `nRST` asserted mid-transfer: all state clears immediately. After release, data bytes are ignored until the next 0x2C.

## Timing
- Latency: pin `nWR` rising edge → `FIFO_WE` high after `SYNC_STAGES`+1 `CLK` edges (3 at the default). `FIFO_DI` is valid in the same cycle.
- `FrameStart` and the FSM state change occur in the same cycle as the `FIFO_WE` slot for that event.
- `FIFO_Full` is sampled in the write cycle, not earlier.
- Bus requirements: `nWR` low ≥ `SYNC_STAGES`+1 `CLK` cycles and high ≥ `SYNC_STAGES`+1 cycles. `DC` and `D` must be stable from the falling edge of `nWR` to `SYNC_STAGES`+1 cycles after its rising edge.
- There is at most one write event per 2·(`SYNC_STAGES`+1) cycles, so there is no back-to-back `FIFO_WE`.

## Structure
- Shared package `lcd_pkg`:
  - DCS command constants (0x01, 0x28, 0x29, 0x2C, 0x3C, 0x51).
  - FSM state enum.
  - `H_ACT`/`V_ACT` defaults, shared with the scan-out side.
- One sub-module, `bus_sync`: parameterised multi-bit synchroniser with edge detect. It outputs the write-event strobe plus the synchronised `DC` and `D`.

## Test plan
- Reset, then 0x29, 0x51, 0x80 → `LCD_BL` = 1, `BL_Level` = 0x80. Then 0x51, 0x00 → `LCD_BL` = 0.
- 0x2C followed by 4 data bytes 0xA1..0xA4, FIFO not full → one `FrameStart` pulse and four `FIFO_WE` pulses with `FIFO_DI` = 0xA1..0xA4. Each pulse occurs 3 cycles after its `nWR` rising edge.
- `H_ACT`=4, `V_ACT`=2: 0x2C then 17 data bytes → exactly 16 `FIFO_WE` pulses, `Busy` falls after the 16th, the 17th byte is ignored.
- `FIFO_Full` = 1 during the 2nd of 3 data bytes → 2 `FIFO_WE` pulses and `Overflow` = 1. The next 0x2C clears `Overflow`.
- 0x2C, 3 data bytes, command 0x00, 0x3C, 2 data bytes → 5 writes total and a single `FrameStart`.
- `nRST` pulsed low mid-MEMWR, then 2 data bytes → no `FIFO_WE`, and every output is at its reset value.
